// File: rtl/axi_lite_regif_bridge.sv
// AXI4-Lite slave front end for a simple register bank (we/wdone, re/rdone).
// Independent write and read engines. Each engine has address-window decode
// (DECERR), an optional privileged-access check (SLVERR), and a per-access
// completion timeout (SLVERR plus a timeout_evt pulse).
module axi_lite_regif_bridge #(
  parameter int unsigned         ADDR_W       = 32,
  parameter int unsigned         DATA_W       = 32,
  parameter logic [ADDR_W-1:0]   ADDR_BASE    = 32'h4000_0000,
  parameter logic [ADDR_W-1:0]   ADDR_SPAN    = 32'h0000_1000,
  parameter int unsigned         TIMEOUT_CYC  = 16,
  parameter int unsigned         REQUIRE_PRIV = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [2:0]          AWPROT,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [2:0]          ARPROT,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic [ADDR_W-1:0]   waddr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                we,
  input  logic                wdone,
  output logic [ADDR_W-1:0]   raddr,
  output logic                re,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rdone,
  output logic                timeout_evt
);

  localparam int unsigned       STRB_W   = DATA_W / 8;
  localparam int unsigned       CNT_W    = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit                TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [ADDR_W:0]   WIN_END  = {1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN};
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [1:0]        RESP_DECERR = 2'b11;

  // The window must fit inside the address space and be a power of two.
  if (WIN_END[ADDR_W] != 1'b0) begin : g_window_overflow
    $error("axi_lite_regif_bridge: ADDR_BASE + ADDR_SPAN overflows ADDR_W");
  end
  if ((ADDR_SPAN == '0) || ((ADDR_SPAN & (ADDR_SPAN - ADDR_W'(1))) != '0)) begin : g_span_pow2
    $error("axi_lite_regif_bridge: ADDR_SPAN must be a non-zero power of two");
  end
  if ((DATA_W != 32) && (DATA_W != 64)) begin : g_data_w
    $error("axi_lite_regif_bridge: DATA_W must be 32 or 64");
  end

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} r_state_t;

  // Unprivileged access is refused when the privilege check is enabled.
  function automatic logic priv_denied(input logic prot0);
    return (REQUIRE_PRIV != 0) && !prot0;
  endfunction

  // Only xPROT[0] matters here; the other bits are intentionally ignored.
  logic unused_prot_s;
  assign unused_prot_s = ^{AWPROT[2:1], ARPROT[2:1]};

  w_state_t          w_state_r, w_state_s;
  logic              awready_r, awready_s, wready_r, wready_s;
  logic [ADDR_W-1:0] waddr_r, waddr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic [STRB_W-1:0] wstrb_r, wstrb_s;
  logic              wpriv_r, wpriv_s;
  logic              we_r, we_s, bvalid_r, bvalid_s;
  logic [1:0]        bresp_r, bresp_s;
  logic [CNT_W-1:0]  wcnt_r, wcnt_s;
  logic              w_to_s, aw_hs_s, w_hs_s;

  r_state_t          r_state_r, r_state_s;
  logic              arready_r, arready_s;
  logic [ADDR_W-1:0] raddr_r, raddr_s;
  logic              re_r, re_s, rvalid_r, rvalid_s;
  logic [DATA_W-1:0] rdata_hold_r, rdata_hold_s;
  logic [1:0]        rresp_r, rresp_s;
  logic [CNT_W-1:0]  rcnt_r, rcnt_s;
  logic              r_to_s, ar_hs_s;
  logic              timeout_evt_r;

  assign aw_hs_s = AWVALID && awready_r;
  assign w_hs_s  = WVALID && wready_r;
  assign ar_hs_s = ARVALID && arready_r;

  // Write engine: capture AW/W in any order, decode, wait for wdone or timeout, hold B.
  always_comb begin
    w_state_s = w_state_r;
    awready_s = awready_r && !aw_hs_s;
    wready_s  = wready_r && !w_hs_s;
    waddr_s   = aw_hs_s ? (AWADDR - ADDR_BASE) : waddr_r;
    wpriv_s   = aw_hs_s ? AWPROT[0] : wpriv_r;
    wdata_s   = w_hs_s ? WDATA : wdata_r;
    wstrb_s   = w_hs_s ? WSTRB : wstrb_r;
    we_s      = we_r;
    bvalid_s  = bvalid_r;
    bresp_s   = bresp_r;
    wcnt_s    = wcnt_r;
    w_to_s    = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if ((aw_hs_s || !awready_r) && (w_hs_s || !wready_r)) begin
          // Offset compare is an unsigned window check since the window cannot wrap.
          if (waddr_s >= ADDR_SPAN) begin
            w_state_s = W_RESP;
            bvalid_s  = 1'b1;
            bresp_s   = RESP_DECERR;
          end else if (priv_denied(wpriv_s)) begin
            w_state_s = W_RESP;
            bvalid_s  = 1'b1;
            bresp_s   = RESP_SLVERR;
          end else begin
            w_state_s = W_REQ;
            we_s      = 1'b1;
            wcnt_s    = '0;
          end
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_REQ: begin
        if (wdone) begin
          w_state_s = W_RESP;
          we_s      = 1'b0;
          bvalid_s  = 1'b1;
          bresp_s   = RESP_OKAY;
        end else if (TO_EN && (wcnt_r == CNT_LAST)) begin
          w_state_s = W_RESP;
          we_s      = 1'b0;
          bvalid_s  = 1'b1;
          bresp_s   = RESP_SLVERR;
          w_to_s    = 1'b1;
        end else begin
          wcnt_s = (wcnt_r == '1) ? wcnt_r : wcnt_r + CNT_W'(1);
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_s = W_IDLE;
          bvalid_s  = 1'b0;
          awready_s = 1'b1;
          wready_s  = 1'b1;
        end else begin
          bvalid_s = 1'b1;
        end
      end
      default: begin
        w_state_s = W_IDLE;
      end
    endcase
  end

  // Read engine: decode on AR handshake, wait for rdone or timeout, hold R.
  always_comb begin
    r_state_s    = r_state_r;
    arready_s    = arready_r && !ar_hs_s;
    raddr_s      = ar_hs_s ? (ARADDR - ADDR_BASE) : raddr_r;
    re_s         = re_r;
    rvalid_s     = rvalid_r;
    rdata_hold_s = rdata_hold_r;
    rresp_s      = rresp_r;
    rcnt_s       = rcnt_r;
    r_to_s       = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          if (raddr_s >= ADDR_SPAN) begin
            r_state_s    = R_RESP;
            rvalid_s     = 1'b1;
            rdata_hold_s = '0;
            rresp_s      = RESP_DECERR;
          end else if (priv_denied(ARPROT[0])) begin
            r_state_s    = R_RESP;
            rvalid_s     = 1'b1;
            rdata_hold_s = '0;
            rresp_s      = RESP_SLVERR;
          end else begin
            r_state_s = R_REQ;
            re_s      = 1'b1;
            rcnt_s    = '0;
          end
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_REQ: begin
        if (rdone) begin
          r_state_s    = R_RESP;
          re_s         = 1'b0;
          rvalid_s     = 1'b1;
          rdata_hold_s = rdata;
          rresp_s      = RESP_OKAY;
        end else if (TO_EN && (rcnt_r == CNT_LAST)) begin
          r_state_s    = R_RESP;
          re_s         = 1'b0;
          rvalid_s     = 1'b1;
          rdata_hold_s = '0;
          rresp_s      = RESP_SLVERR;
          r_to_s       = 1'b1;
        end else begin
          rcnt_s = (rcnt_r == '1) ? rcnt_r : rcnt_r + CNT_W'(1);
        end
      end
      R_RESP: begin
        if (RREADY) begin
          r_state_s = R_IDLE;
          rvalid_s  = 1'b0;
          arready_s = 1'b1;
        end else begin
          rvalid_s = 1'b1;
        end
      end
      default: begin
        r_state_s = R_IDLE;
      end
    endcase
  end

  // Write engine state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b1;
      wready_r  <= 1'b1;
      waddr_r   <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      wpriv_r   <= 1'b0;
      we_r      <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      wcnt_r    <= '0;
    end else begin
      w_state_r <= w_state_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      waddr_r   <= waddr_s;
      wdata_r   <= wdata_s;
      wstrb_r   <= wstrb_s;
      wpriv_r   <= wpriv_s;
      we_r      <= we_s;
      bvalid_r  <= bvalid_s;
      bresp_r   <= bresp_s;
      wcnt_r    <= wcnt_s;
    end
  end

  // Read engine state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_r    <= R_IDLE;
      arready_r    <= 1'b1;
      raddr_r      <= '0;
      re_r         <= 1'b0;
      rvalid_r     <= 1'b0;
      rdata_hold_r <= '0;
      rresp_r      <= 2'b00;
      rcnt_r       <= '0;
    end else begin
      r_state_r    <= r_state_s;
      arready_r    <= arready_s;
      raddr_r      <= raddr_s;
      re_r         <= re_s;
      rvalid_r     <= rvalid_s;
      rdata_hold_r <= rdata_hold_s;
      rresp_r      <= rresp_s;
      rcnt_r       <= rcnt_s;
    end
  end

  // One pulse covers simultaneous read and write timeouts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_evt_r <= 1'b0;
    end else begin
      timeout_evt_r <= w_to_s || r_to_s;
    end
  end

  assign AWREADY     = awready_r;
  assign WREADY      = wready_r;
  assign BVALID      = bvalid_r;
  assign BRESP       = bresp_r;
  assign waddr       = waddr_r;
  assign wdata       = wdata_r;
  assign wstrb       = wstrb_r;
  assign we          = we_r;
  assign ARREADY     = arready_r;
  assign RVALID      = rvalid_r;
  assign RDATA       = rdata_hold_r;
  assign RRESP       = rresp_r;
  assign raddr       = raddr_r;
  assign re          = re_r;
  assign timeout_evt = timeout_evt_r;

endmodule

// File: tb/tb_axi_lite_regif_bridge.sv
// Bench for axi_lite_regif_bridge: directed scenarios plus randomized
// transactions. Expected values come from a transaction-level model.
module tb_axi_lite_regif_bridge;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;
  localparam int          TMO  = 16;

  logic        clk, rst;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, waddr, wdata, raddr, rdata;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB, wstrb;
  logic [1:0]  BRESP, RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        we, wdone, re, rdone, timeout_evt;

  int checks = 0;
  int errors = 0;

  axi_lite_regif_bridge #(
    .ADDR_W(32), .DATA_W(32), .ADDR_BASE(BASE), .ADDR_SPAN(SPAN),
    .TIMEOUT_CYC(TMO), .REQUIRE_PRIV(1)
  ) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .we(we), .wdone(wdone),
    .raddr(raddr), .re(re), .rdata(rdata), .rdone(rdone),
    .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: window membership computed on wide integers.
  function automatic bit in_win(input logic [31:0] a);
    longint unsigned x, lo, hi;
    x  = a;
    lo = BASE;
    hi = longint'(BASE) + longint'(SPAN);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [2:0] prot, input int done_at);
    if (!in_win(a)) return 2'b11;
    if (!prot[0]) return 2'b10;
    if (done_at < 0 || done_at > TMO - 1) return 2'b10;
    return 2'b00;
  endfunction

  // Cycle at which the response appears; hs is the cycle of the last address/data beat.
  function automatic int model_resp_cycle(input int hs, input bit ok, input int done_at);
    if (!ok) return hs + 1;
    if (done_at >= 0 && done_at <= TMO - 1) return hs + 2 + done_at;
    return hs + 1 + TMO;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_awready"}, AWREADY, 1'b1);
    chk({tag, "_wready"}, WREADY, 1'b1);
    chk({tag, "_arready"}, ARREADY, 1'b1);
    chk({tag, "_bvalid"}, BVALID, 1'b0);
    chk({tag, "_rvalid"}, RVALID, 1'b0);
    chk({tag, "_we"}, we, 1'b0);
    chk({tag, "_re"}, re, 1'b0);
    chk({tag, "_tevt"}, timeout_evt, 1'b0);
    chk({tag, "_bresp"}, BRESP, 2'b00);
    chk({tag, "_rresp"}, RRESP, 2'b00);
    chk({tag, "_rdata_out"}, RDATA, 32'h0);
    chk({tag, "_waddr"}, waddr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_wstrb"}, wstrb, 4'h0);
    chk({tag, "_raddr"}, raddr, 32'h0);
  endtask

  // One write: AW at cycle aw_at, W at cycle w_at, wdone done_at cycles after we rises
  // (-1 = never), BREADY raised bw cycles after BVALID.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, input int aw_at, input int w_at,
                           input int done_at, input int bw);
    bit ok;
    logic [1:0] er;
    int hs, rc, last;
    ok   = in_win(addr) && prot[0];
    er   = model_resp(addr, prot, done_at);
    hs   = (aw_at > w_at) ? aw_at : w_at;
    rc   = model_resp_cycle(hs, ok, done_at);
    last = rc + bw + 1;
    AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
    for (int c = 0; c <= last; c++) begin
      bit we_exp, bv_exp;
      we_exp = ok && (c > hs) && (c < rc);
      bv_exp = (c >= rc) && (c <= rc + bw);
      chk("w_we", we, we_exp);
      if (we_exp) begin
        chk("w_waddr", waddr, addr - BASE);
        chk("w_wdata", wdata, data);
        chk("w_wstrb", wstrb, strb);
      end
      chk("w_bvalid", BVALID, bv_exp);
      if (bv_exp) chk("w_bresp", BRESP, er);
      chk("w_awready", AWREADY, (c <= aw_at) || (c > rc + bw));
      chk("w_wready", WREADY, (c <= w_at) || (c > rc + bw));
      chk("w_tevt", timeout_evt, ok && (er == 2'b10) && (c == rc));
      AWVALID = (c == aw_at);
      WVALID  = (c == w_at);
      wdone   = ok && (done_at >= 0) && (c == hs + 1 + done_at);
      BREADY  = (c >= rc + bw);
      tick();
    end
    AWVALID = 1'b0; WVALID = 1'b0; wdone = 1'b0; BREADY = 1'b0;
  endtask

  // One read: AR at cycle 0, rdone done_at cycles after re rises (-1 = never).
  task automatic read_txn(input logic [31:0] addr, input logic [2:0] prot, input int done_at,
                          input int rw, input logic [31:0] rdval);
    bit ok;
    logic [1:0] er;
    int rc, last;
    ok   = in_win(addr) && prot[0];
    er   = model_resp(addr, prot, done_at);
    rc   = model_resp_cycle(0, ok, done_at);
    last = rc + rw + 1;
    ARADDR = addr; ARPROT = prot;
    for (int c = 0; c <= last; c++) begin
      bit re_exp, rv_exp;
      re_exp = ok && (c >= 1) && (c < rc);
      rv_exp = (c >= rc) && (c <= rc + rw);
      chk("r_re", re, re_exp);
      if (re_exp) chk("r_raddr", raddr, addr - BASE);
      chk("r_rvalid", RVALID, rv_exp);
      if (rv_exp) begin
        chk("r_rresp", RRESP, er);
        chk("r_rdata", RDATA, (er == 2'b00) ? rdval : 32'h0);
      end
      chk("r_arready", ARREADY, (c == 0) || (c > rc + rw));
      chk("r_tevt", timeout_evt, ok && (er == 2'b10) && (c == rc));
      ARVALID = (c == 0);
      rdone   = ok && (done_at >= 0) && (c == 1 + done_at);
      rdata   = rdone ? rdval : $urandom();
      RREADY  = (c >= rc + rw);
      tick();
    end
    ARVALID = 1'b0; rdone = 1'b0; RREADY = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] off;
    off = 32'($urandom_range(0, 4095));
    case ($urandom_range(0, 4))
      0, 1:    return BASE + off;
      2:       return BASE + SPAN + off;
      3:       return BASE - 32'd1 - off;
      default: return $urandom();
    endcase
  endfunction

  function automatic int rand_done();
    case ($urandom_range(0, 7))
      0:       return -1;
      1:       return TMO - 1;
      2:       return TMO;
      default: return $urandom_range(0, 5);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    wdone = 1'b0; rdone = 1'b0; rdata = '0;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0;
    tick();
    check_reset("post_rel");

    // Stray completions while idle must be ignored.
    wdone = 1'b1; rdone = 1'b1; rdata = 32'hA5A5_5A5A;
    tick(); tick();
    wdone = 1'b0; rdone = 1'b0;
    check_reset("stray_done");

    // Basic write, wdone 3 cycles after we.
    write_txn(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 0, 3, 0);
    // W beat 4 cycles before AW, BREADY held low 5 cycles.
    write_txn(32'h4000_0124, 32'h1234_5678, 4'h5, 3'b001, 4, 0, 0, 5);
    // AW before W.
    write_txn(32'h4000_0FFC, 32'hCAFE_F00D, 4'hC, 3'b011, 0, 2, 1, 1);
    // Out of window above and below.
    write_txn(32'h4000_1000, 32'h1111_1111, 4'hF, 3'b001, 0, 0, 0, 0);
    write_txn(32'h3FFF_FFFF, 32'h2222_2222, 4'hF, 3'b001, 1, 0, 0, 2);
    // Privilege check: unprivileged refused, then privileged accepted.
    write_txn(32'h4000_0040, 32'h3333_3333, 4'hF, 3'b000, 0, 0, 2, 0);
    write_txn(32'h4000_0040, 32'h3333_3333, 4'hF, 3'b001, 0, 0, 2, 0);
    // Write timeout, and wdone on the timeout cycle.
    write_txn(32'h4000_0080, 32'h4444_4444, 4'h3, 3'b001, 0, 0, -1, 1);
    write_txn(32'h4000_0084, 32'h5555_5555, 4'hF, 3'b001, 0, 0, TMO - 1, 0);

    // Reads: just outside window, in window, timeout, rdone on timeout cycle, unprivileged.
    read_txn(32'h4000_1000, 3'b001, 2, 0, 32'h9999_9999);
    read_txn(32'h4000_0200, 3'b001, 2, 3, 32'h8765_4321);
    read_txn(32'h4000_0020, 3'b001, -1, 0, 32'h0);
    read_txn(32'h4000_0000, 3'b101, TMO - 1, 1, 32'hFEED_FACE);
    read_txn(32'h4000_0004, 3'b110, 1, 0, 32'h7777_7777);

    // Simultaneous write and read timeouts give one timeout_evt pulse.
    AWADDR = BASE + 32'h8; AWPROT = 3'b001; WDATA = 32'h600D_0001; WSTRB = 4'hF;
    ARADDR = BASE + 32'hC; ARPROT = 3'b001;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("dual_we", we, 1'b1);
    chk("dual_re", re, 1'b1);
    repeat (TMO - 1) tick();
    chk("dual_we_last", we, 1'b1);
    chk("dual_tevt_early", timeout_evt, 1'b0);
    tick();
    chk("dual_tevt", timeout_evt, 1'b1);
    chk("dual_bvalid", BVALID, 1'b1);
    chk("dual_rvalid", RVALID, 1'b1);
    chk("dual_bresp", BRESP, 2'b10);
    chk("dual_rresp", RRESP, 2'b10);
    chk("dual_rdata", RDATA, 32'h0);
    chk("dual_we_off", we, 1'b0);
    tick();
    chk("dual_tevt_once", timeout_evt, 1'b0);
    chk("dual_bvalid_hold", BVALID, 1'b1);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    chk("dual_awready", AWREADY, 1'b1);
    chk("dual_arready", ARREADY, 1'b1);
    chk("dual_bvalid_off", BVALID, 1'b0);

    // Reset while both a write and a read are in flight.
    AWADDR = BASE + 32'h40; AWPROT = 3'b001; WDATA = 32'hABCD_0123; WSTRB = 4'h9;
    ARADDR = BASE + 32'h44; ARPROT = 3'b001;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    tick();
    chk("inflight_we", we, 1'b1);
    chk("inflight_re", re, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset("async_rst");
    tick();
    rst = 1'b0;
    repeat (TMO + 4) begin
      chk("drop_bvalid", BVALID, 1'b0);
      chk("drop_rvalid", RVALID, 1'b0);
      chk("drop_tevt", timeout_evt, 1'b0);
      tick();
    end
    write_txn(32'h4000_0048, 32'h0BAD_CAFE, 4'hF, 3'b001, 0, 0, 1, 0);
    read_txn(32'h4000_0048, 3'b001, 0, 0, 32'h0BAD_CAFE);

    // Randomized transactions against the model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [2:0]  prot;
      a    = rand_addr();
      prot = {2'($urandom), ($urandom_range(0, 3) != 0)};
      if ((i % 2) == 0)
        write_txn(a, $urandom(), 4'($urandom()), prot, $urandom_range(0, 3),
                  $urandom_range(0, 3), rand_done(), $urandom_range(0, 2));
      else
        read_txn(a, prot, rand_done(), $urandom_range(0, 2), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_regif_bridge.md
Name: axi_lite_regif_bridge

Overview:
Parametrised AXI4-Lite slave that bridges one AXI-Lite port to the simple register-interface handshake (we/wdone, re/rdone).
- Adds configurable widths, address-window decode with DECERR, a per-access completion timeout with SLVERR, and an optional privileged-access check.
- Passes write strobes through to the register file.
- Sits between the PS interconnect and each PL register bank.

Parameters:
ADDR_W, 32, AXI and register address width
DATA_W, 32, data width (32 or 64); strobe width is DATA_W/8
ADDR_BASE, 32'h4000_0000, first byte address of the decoded window
ADDR_SPAN, 32'h0000_1000, window size in bytes (power of two)
TIMEOUT_CYC, 16, max cycles waiting for wdone/rdone; 0 disables timeout
REQUIRE_PRIV, 0, when 1, accesses with xPROT[0]=0 get SLVERR with no register access

Ports:
clk in 1 clock
rst in 1 async active-high reset
AWADDR in ADDR_W; AWPROT in 3; AWVALID in 1; AWREADY out 1 (write address channel)
WDATA in DATA_W; WSTRB in DATA_W/8; WVALID in 1; WREADY out 1 (write data channel)
BVALID out 1; BREADY in 1; BRESP out 2 (write response)
ARADDR in ADDR_W; ARPROT in 3; ARVALID in 1; ARREADY out 1 (read address channel)
RVALID out 1; RREADY in 1; RDATA out DATA_W; RRESP out 2 (read data)
waddr out ADDR_W: byte offset (AWADDR-ADDR_BASE)
wdata out DATA_W; wstrb out DATA_W/8; we out 1: write request
wdone in 1: register bank write complete
raddr out ADDR_W: byte offset (ARADDR-ADDR_BASE)
re out 1: read request
rdata in DATA_W; rdone in 1: read data valid
timeout_evt out 1: single-cycle pulse on any timeout abort

Behaviour:
- Reset (async, immediate):
  - AWREADY=WREADY=ARREADY=1.
  - BVALID=RVALID=we=re=timeout_evt=0.
  - BRESP=RRESP=0; RDATA, waddr, wdata, wstrb, raddr all 0.
  - In-flight accesses are dropped; no B/R response is issued for them.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - AW and W are captured independently in any order. On each handshake the corresponding READY drops next cycle and the field is held.
  - W_IDLE: when both are held, evaluate the access the next cycle.
    - Address outside [ADDR_BASE, ADDR_BASE+ADDR_SPAN), or PROT check fails: go to W_RESP with BRESP=11 (DECERR) or 10 (SLVERR). we is never asserted.
    - Otherwise: assert we, go to W_REQ.
  - Latency: AW+W handshake in cycle 0 gives we=1 in cycle 1.
  - W_REQ: we held high; waddr/wdata/wstrb stable.
    - wdone sampled high: we=0 and BVALID=1 with BRESP=00 the next cycle.
    - Timeout: counter reaches TIMEOUT_CYC with no wdone. Then we=0, BVALID=1, BRESP=10, timeout_evt=1 for one cycle.
    - wdone in the same cycle as timeout: wdone wins, response OKAY.
  - W_RESP: BVALID held until BREADY. After the handshake, AWREADY=WREADY=1 the next cycle and return to W_IDLE.
  - One write outstanding; AWREADY/WREADY stay low through W_REQ and W_RESP.
  - wdone outside W_REQ is ignored.
- Read FSM states: R_IDLE, R_REQ, R_RESP. Fully independent of the write FSM; reads and writes may overlap.
  - AR handshake in cycle 0: ARREADY=0 in cycle 1. Decode/PROT error goes to R_RESP with RDATA=0 and RRESP=11/10. Otherwise re=1 in cycle 1.
  - R_REQ: rdone registers rdata into RDATA with RRESP=00, re=0, RVALID=1 the next cycle.
  - Timeout: RDATA=0, RRESP=10, timeout_evt pulse.
  - rdone in the same cycle as timeout: rdone wins.
  - RVALID and RDATA are held until RREADY; ARREADY=1 the cycle after the R handshake.
- Timeout counter:
  - Width clog2(TIMEOUT_CYC+1).
  - Cleared on entering W_REQ/R_REQ (separate counters).
  - Saturates; never wraps.
  - TIMEOUT_CYC=0: wait indefinitely.
- Simultaneous read and write timeouts produce a single timeout_evt pulse.
- Address arithmetic:
  - Offset is computed modulo 2^ADDR_W.
  - The window check uses unsigned compares. ADDR_BASE+ADDR_SPAN must not overflow ADDR_W, enforced by an elaboration assertion.
  - Low address bits are passed unmodified; no alignment check.

Test Plan:
- Write AWADDR=0x4000_0010, WDATA=0xDEADBEEF, WSTRB=0xF, wdone 3 cycles after we -> we=1 cycle 1, waddr=0x10, BVALID with BRESP=00 on cycle 5, ready re-opens after BREADY.
- W beat 4 cycles before AW beat, BREADY held low 5 cycles -> single we burst; BVALID stable; AWREADY/WREADY low until B handshake.
- Read ARADDR=0x4000_1000 (just outside window) -> re never asserted, RVALID with RRESP=11, RDATA=0.
- Read in-window, rdone never asserted, TIMEOUT_CYC=16 -> re low after 16 cycles, RRESP=10, timeout_evt single pulse.
- REQUIRE_PRIV=1, write with AWPROT=000 -> BRESP=10, we never asserted; repeat with AWPROT=001 -> OKAY.
- Concurrent write and read in-window, rst asserted while we=1 and re=1 -> all outputs at reset values immediately, no B/R response; post-reset write completes normally.
